// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch scheduler.
package sprite_pkg;

    localparam int ROM_AW = 13;

    typedef enum logic [2:0] {
        UP    = 3'b001,
        RIGHT = 3'b010,
        LEFT  = 3'b011,
        DOWN  = 3'b100
    } dir_t;

    typedef enum logic [1:0] {
        L_BULLET = 2'd0,
        L_TANK1  = 2'd1,
        L_TANK2  = 2'd2
    } layer_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE1 = 2'd1,
        S_EVAL1  = 2'd2,
        S_EVAL2  = 2'd3
    } fsm_state_t;

    localparam logic [ROM_AW-1:0] FRAME_UP    = 13'd0;
    localparam logic [ROM_AW-1:0] FRAME_RIGHT = 13'd1024;
    localparam logic [ROM_AW-1:0] FRAME_LEFT  = 13'd2048;
    localparam logic [ROM_AW-1:0] FRAME_DOWN  = 13'd3072;
    localparam logic [ROM_AW-1:0] BULLET_BASE = 13'd4096;

    // Undefined direction codes fall back to the up-facing frame.
    function automatic logic [ROM_AW-1:0] frame_base(input logic [2:0] dir);
        case (dir)
            RIGHT:   frame_base = FRAME_RIGHT;
            LEFT:    frame_base = FRAME_LEFT;
            DOWN:    frame_base = FRAME_DOWN;
            default: frame_base = FRAME_UP;
        endcase
    endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_if.sv
// Pixel request, sprite ROM and VGA output signals of the fetch scheduler.
interface sprite_fetch_scheduler_if;
    logic        pixel_stb;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        mode;
    logic [9:0]  tankX1, tankY1, tankX2, tankY2, tankX3, tankY3;
    logic [2:0]  tank_dir1, tank_dir2, tank_dir3;
    logic        bullet_active;
    logic [9:0]  bullet_X, bullet_Y;
    logic [12:0] rom_addr;
    logic [23:0] rom_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid;
    logic        overrun;
    logic        overrun_clr;

    modport slave (
        input  pixel_stb, DrawX, DrawY, mode,
        input  tankX1, tankY1, tankX2, tankY2, tankX3, tankY3,
        input  tank_dir1, tank_dir2, tank_dir3,
        input  bullet_active, bullet_X, bullet_Y,
        input  rom_data, overrun_clr,
        output rom_addr, VGA_R, VGA_G, VGA_B, pix_valid, overrun
    );

    modport master (
        output pixel_stb, DrawX, DrawY, mode,
        output tankX1, tankY1, tankX2, tankY2, tankX3, tankY3,
        output tank_dir1, tank_dir2, tank_dir3,
        output bullet_active, bullet_X, bullet_Y,
        output rom_data, overrun_clr,
        input  rom_addr, VGA_R, VGA_G, VGA_B, pix_valid, overrun
    );
endinterface

// File: rtl/sprite_hit_addr.sv
// Combinational hit test and ROM address for one sprite layer.
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int STRIDE  = 32,
    parameter bit USE_DIR = 1'b1
) (
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [2:0]        dir,
    input  logic [ROM_AW-1:0] base_fixed,
    output logic              hit,
    output logic [ROM_AW-1:0] addr
);
    logic [10:0]       x_hi, y_hi;
    logic [9:0]        dx, dy;
    logic [ROM_AW-1:0] base;

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        x_hi = {1'b0, pos_x} + 11'(SIZE);
        y_hi = {1'b0, pos_y} + 11'(SIZE);
        hit  = (draw_x >= pos_x) && ({1'b0, draw_x} < x_hi) &&
               (draw_y >= pos_y) && ({1'b0, draw_y} < y_hi);
        dx   = draw_x - pos_x;
        dy   = draw_y - pos_y;
        base = USE_DIR ? frame_base(dir) : base_fixed;
        addr = base + ROM_AW'(dy) * ROM_AW'(STRIDE) + ROM_AW'(dx);
    end
endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares one single-port sprite ROM between bullet and two tank layers,
// resolving colour-key transparency with at most two reads per pixel.
module sprite_fetch_scheduler
    import sprite_pkg::*;
#(
    parameter int          TANK_SIZE   = 32,
    parameter int          BULLET_SIZE = 8,
    parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
    parameter logic [23:0] BG_COLOR    = 24'hFFFFFF
) (
    input logic                   Clk,
    input logic                   Reset_n,
    sprite_fetch_scheduler_if.slave bus
);
    logic [2:0]        hit_v;
    logic [ROM_AW-1:0] addr_v [3];
    logic [9:0]        slot_x, slot_y;
    logic [2:0]        slot_dir;

    logic [ROM_AW-1:0] list0, list1;
    logic [1:0]        list_cnt;

    fsm_state_t        state_q, state_d;
    logic [ROM_AW-1:0] cand0_q, cand0_d, cand1_q, cand1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              pend_q, pend_d;
    logic [23:0]       result_q, result_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              pix_valid_q, pix_valid_d;
    logic              overrun_q, overrun_d;
    logic [23:0]       pix_final;

    // Second tank slot is selected before hit testing so only three layers are tested.
    always_comb begin
        slot_x   = bus.mode ? bus.tankX3    : bus.tankX2;
        slot_y   = bus.mode ? bus.tankY3    : bus.tankY2;
        slot_dir = bus.mode ? bus.tank_dir3 : bus.tank_dir2;
    end

    logic bullet_hit;

    sprite_hit_addr #(.SIZE(BULLET_SIZE), .STRIDE(BULLET_SIZE), .USE_DIR(1'b0)) u_bullet (
        .pos_x(bus.bullet_X), .pos_y(bus.bullet_Y),
        .draw_x(bus.DrawX), .draw_y(bus.DrawY),
        .dir(3'b000), .base_fixed(BULLET_BASE),
        .hit(bullet_hit), .addr(addr_v[L_BULLET])
    );

    sprite_hit_addr #(.SIZE(TANK_SIZE), .STRIDE(TANK_SIZE), .USE_DIR(1'b1)) u_tank1 (
        .pos_x(bus.tankX1), .pos_y(bus.tankY1),
        .draw_x(bus.DrawX), .draw_y(bus.DrawY),
        .dir(bus.tank_dir1), .base_fixed(13'd0),
        .hit(hit_v[L_TANK1]), .addr(addr_v[L_TANK1])
    );

    sprite_hit_addr #(.SIZE(TANK_SIZE), .STRIDE(TANK_SIZE), .USE_DIR(1'b1)) u_tank2 (
        .pos_x(slot_x), .pos_y(slot_y),
        .draw_x(bus.DrawX), .draw_y(bus.DrawY),
        .dir(slot_dir), .base_fixed(13'd0),
        .hit(hit_v[L_TANK2]), .addr(addr_v[L_TANK2])
    );

    assign hit_v[L_BULLET] = bullet_hit && bus.bullet_active;

    // Build the priority-ordered candidate list; the third entry is never fetched.
    always_comb begin
        list0    = '0;
        list1    = '0;
        list_cnt = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (hit_v[i]) begin
                if (list_cnt == 2'd0)      list0 = addr_v[i];
                else if (list_cnt == 2'd1) list1 = addr_v[i];
                list_cnt = list_cnt + 2'd1;
            end
        end
    end

    // FSM next-state, ROM address and result selection.
    always_comb begin
        state_d     = state_q;
        cand0_d     = cand0_q;
        cand1_d     = cand1_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        pend_d      = pend_q;
        result_d    = result_q;
        rgb_d       = rgb_q;
        pix_valid_d = 1'b0;
        overrun_d   = overrun_q;
        pix_final   = result_q;

        if (bus.overrun_clr)                          overrun_d = 1'b0;
        if (bus.pixel_stb && (state_q != S_IDLE))     overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.pixel_stb) begin
                    cand0_d = list0;
                    cand1_d = list1;
                    cnt_d   = list_cnt;
                    pend_d  = 1'b0;
                    state_d = S_ISSUE1;
                end
            end
            S_ISSUE1: begin
                rom_addr_d = (cnt_q != 2'd0) ? cand0_q : '0;
                state_d    = S_EVAL1;
            end
            S_EVAL1: begin
                if (cnt_q == 2'd0) begin
                    result_d = BG_COLOR;
                end else if (bus.rom_data != KEY_COLOR) begin
                    result_d = bus.rom_data;
                end else if (cnt_q >= 2'd2) begin
                    rom_addr_d = cand1_q;
                    pend_d     = 1'b1;
                end else begin
                    result_d = BG_COLOR;
                end
                state_d = S_EVAL2;
            end
            S_EVAL2: begin
                if (pend_q)
                    pix_final = (bus.rom_data != KEY_COLOR) ? bus.rom_data : BG_COLOR;
                rgb_d       = pix_final;
                pix_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset discards any in-flight pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            rom_addr_q  <= '0;
            pend_q      <= 1'b0;
            rgb_q       <= BG_COLOR;
            pix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            pend_q      <= pend_d;
            rgb_q       <= rgb_d;
            pix_valid_q <= pix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Candidate addresses and intermediate result need no reset; they are always written before use.
    always_ff @(posedge Clk) begin
        cand0_q  <= cand0_d;
        cand1_q  <= cand1_d;
        result_q <= result_d;
    end

    assign bus.rom_addr  = rom_addr_d;
    assign bus.VGA_R     = rgb_q[23:16];
    assign bus.VGA_G     = rgb_q[15:8];
    assign bus.VGA_B     = rgb_q[7:0];
    assign bus.pix_valid = pix_valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed bench for sprite_fetch_scheduler with a 1-cycle-latency ROM model.
module tb_sprite_fetch_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pv_cnt = 0;
    logic [23:0] rom_mem [0:8191];

    sprite_fetch_scheduler_if bus ();

    sprite_fetch_scheduler dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the address seen at an edge appears after it.
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    always @(negedge clk) if (bus.pix_valid === 1'b1) pv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe sampled at the next edge; returns 1 time unit into cycle 1.
    task automatic drive_stb(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        bus.DrawX = x;
        bus.DrawY = y;
        bus.pixel_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.pixel_stb = 1'b0;
    endtask

    task automatic run_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [12:0] a0, input bit chk_a1, input logic [12:0] a1,
                             input logic [23:0] rgb);
        drive_stb(x, y);
        chk({tag, "_addr0"}, 32'(bus.rom_addr), 32'(a0));
        chk({tag, "_pv_c1"}, 32'(bus.pix_valid), 32'd0);
        tick();
        if (chk_a1) chk({tag, "_addr1"}, 32'(bus.rom_addr), 32'(a1));
        tick();
        chk({tag, "_pv_c3"}, 32'(bus.pix_valid), 32'd0);
        tick();
        chk({tag, "_pv_c4"}, 32'(bus.pix_valid), 32'd1);
        chk({tag, "_rgb"}, 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(rgb));
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 24'h000000;
        bus.pixel_stb = 0; bus.DrawX = 0; bus.DrawY = 0; bus.mode = 0;
        bus.tankX1 = 10'd700; bus.tankY1 = 10'd700; bus.tank_dir1 = 3'b001;
        bus.tankX2 = 10'd700; bus.tankY2 = 10'd700; bus.tank_dir2 = 3'b001;
        bus.tankX3 = 10'd700; bus.tankY3 = 10'd700; bus.tank_dir3 = 3'b001;
        bus.bullet_active = 0; bus.bullet_X = 10'd700; bus.bullet_Y = 10'd700;
        bus.overrun_clr = 0;

        repeat (3) tick();
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_pv", 32'(bus.pix_valid), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        chk("rst_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'hFFFFFF);
        @(negedge clk) rst_n = 1'b1;
        tick();

        run_pixel("empty", 10'd0, 10'd0, 13'd0, 1'b0, 13'd0, 24'hFFFFFF);

        // Tank 1 only; positions change mid-pixel must not matter.
        bus.tankX1 = 10'd100; bus.tankY1 = 10'd50; bus.tank_dir1 = 3'b010;
        rom_mem[1093] = 24'h123456;
        drive_stb(10'd105, 10'd52);
        bus.tankX1 = 10'd500; bus.tank_dir1 = 3'b100;
        chk("t1_addr0", 32'(bus.rom_addr), 32'd1093);
        repeat (3) tick();
        chk("t1_pv", 32'(bus.pix_valid), 32'd1);
        chk("t1_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'h123456);
        bus.tankX1 = 10'd100; bus.tank_dir1 = 3'b010;

        // Bullet over tank 1.
        bus.bullet_active = 1; bus.bullet_X = 10'd104; bus.bullet_Y = 10'd50;
        rom_mem[4113] = 24'h00FF00;
        run_pixel("bul_opq", 10'd105, 10'd52, 13'd4113, 1'b0, 13'd0, 24'h00FF00);
        rom_mem[4113] = 24'hFF0000;
        run_pixel("bul_key", 10'd105, 10'd52, 13'd4113, 1'b1, 13'd1093, 24'h123456);

        // Three stacked layers, first two transparent: third never fetched.
        bus.tankX2 = 10'd100; bus.tankY2 = 10'd50; bus.tank_dir2 = 3'b001;
        rom_mem[1093] = 24'hFF0000;
        rom_mem[69]   = 24'h0ABCDE;
        drive_stb(10'd105, 10'd52);
        chk("stk_addr0", 32'(bus.rom_addr), 32'd4113);
        tick();
        chk("stk_addr1", 32'(bus.rom_addr), 32'd1093);
        tick();
        chk("stk_no3rd", 32'(bus.rom_addr != 13'd69), 32'd1);
        tick();
        chk("stk_pv", 32'(bus.pix_valid), 32'd1);
        chk("stk_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'hFFFFFF);

        // Mode switch between tank 2 and tank 3.
        bus.bullet_active = 0; bus.tankX1 = 10'd600; bus.tankY1 = 10'd400;
        bus.mode = 1;
        bus.tankX3 = 10'd200; bus.tankY3 = 10'd200; bus.tank_dir3 = 3'b100;
        bus.tankX2 = 10'd300; bus.tankY2 = 10'd300; bus.tank_dir2 = 3'b011;
        rom_mem[3402] = 24'hA1B2C3;
        rom_mem[2378] = 24'h445566;
        run_pixel("m1_t3", 10'd210, 10'd210, 13'd3402, 1'b0, 13'd0, 24'hA1B2C3);
        run_pixel("m1_t2", 10'd310, 10'd310, 13'd0, 1'b0, 13'd0, 24'hFFFFFF);
        bus.mode = 0;
        run_pixel("m0_t2", 10'd310, 10'd310, 13'd2378, 1'b0, 13'd0, 24'h445566);

        // Clipping at the right edge and bottom boundary of a tank.
        bus.tankX1 = 10'd1010; bus.tankY1 = 10'd5; bus.tank_dir1 = 3'b000;
        rom_mem[42] = 24'h0C0C0C;
        run_pixel("clip_hit", 10'd1020, 10'd6, 13'd42, 1'b0, 13'd0, 24'h0C0C0C);
        run_pixel("clip_xlo", 10'd1009, 10'd6, 13'd0, 1'b0, 13'd0, 24'hFFFFFF);
        run_pixel("clip_ybot", 10'd1020, 10'd37, 13'd0, 1'b0, 13'd0, 24'hFFFFFF);
        chk("no_ovr_b2b", 32'(bus.overrun), 32'd0);

        // Overrun: second strobe two cycles after the first is dropped.
        tick();
        pv_cnt = 0;
        drive_stb(10'd1020, 10'd6);
        tick();
        drive_stb(10'd1020, 10'd6);
        repeat (6) tick();
        chk("ovr_pv_cnt", 32'(pv_cnt), 32'd1);
        chk("ovr_set", 32'(bus.overrun), 32'd1);
        @(negedge clk) bus.overrun_clr = 1'b1;
        @(posedge clk) #1 bus.overrun_clr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 32'd0);

        // Clear and dropping strobe in the same cycle: set wins.
        drive_stb(10'd1020, 10'd6);
        tick();
        @(negedge clk) begin bus.pixel_stb = 1'b1; bus.overrun_clr = 1'b1; end
        @(posedge clk) #1 begin bus.pixel_stb = 1'b0; bus.overrun_clr = 1'b0; end
        chk("ovr_setwins", 32'(bus.overrun), 32'd1);
        repeat (4) tick();

        // Reset mid-pixel after a coloured pixel.
        run_pixel("pre_rst", 10'd1020, 10'd6, 13'd42, 1'b0, 13'd0, 24'h0C0C0C);
        tick();
        pv_cnt = 0;
        drive_stb(10'd1020, 10'd6);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_addr", 32'(bus.rom_addr), 32'd0);
        chk("mrst_pv", 32'(bus.pix_valid), 32'd0);
        chk("mrst_ovr", 32'(bus.overrun), 32'd0);
        chk("mrst_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'hFFFFFF);
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        repeat (6) tick();
        chk("mrst_no_pv", 32'(pv_cnt), 32'd0);
        run_pixel("post_rst", 10'd1020, 10'd6, 13'd42, 1'b0, 13'd0, 24'h0C0C0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_fetch_scheduler.md
Name: sprite_fetch_scheduler

Overview:
- Per-pixel scheduler that shares one single-port sprite ROM (1-cycle read latency) between three layers: bullet, tank 1, and a second tank slot.
- The second tank slot is tank 2 when mode=0 and tank 3 when mode=1.
- For each pixel strobe it does hit testing, orders the candidate layers by priority, and issues up to two ROM reads with colour-key transparency fall-through.
- It delivers a registered RGB pixel at a fixed latency to the VGA output stage.
- Clk runs at 4x the pixel rate (100 MHz PLL output vs 25 MHz pixel clock).

Parameters:
- TANK_SIZE, 32: tank sprite width/height in pixels; also the ROM row stride for tank frames.
- BULLET_SIZE, 8: bullet sprite width/height; also the ROM row stride for the bullet frame.
- KEY_COLOR, 24'hFF0000: transparent colour key.
- BG_COLOR, 24'hFFFFFF: colour output when no opaque layer is found.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- pixel_stb  in  1  one-cycle pulse; DrawX/DrawY are valid for this pixel
- DrawX, DrawY  in  10 each  pixel coordinate
- mode  in  1  0: second slot uses tank 2; 1: second slot uses tank 3
- tankX1, tankY1, tankX2, tankY2, tankX3, tankY3  in  10 each  tank top-left positions
- tank_dir1, tank_dir2, tank_dir3  in  3 each  001 up, 010 right, 011 left, 100 down
- bullet_active  in  1  bullet is drawn
- bullet_X, bullet_Y  in  10 each  bullet top-left position
- rom_addr  out  13  sprite ROM read address
- rom_data  in  24  ROM data for the address sampled on the previous edge
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour
- pix_valid  out  1  one-cycle pulse; VGA_R/G/B hold the new pixel
- overrun  out  1  sticky flag: a strobe arrived while busy
- overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state=IDLE, rom_addr=0, pix_valid=0, overrun=0.
  - VGA_R/G/B = BG_COLOR bytes (FF, FF, FF).
  - Any in-flight pixel is discarded and no pix_valid is produced for it.
- Hit test, done in IDLE on pixel_stb:
  - Hit means X <= DrawX < X+SIZE and Y <= DrawY < Y+SIZE.
  - Compare in 11 bits so X+SIZE never wraps; sprites partly past 1023 clip.
- Priority order: bullet (only if bullet_active), then tank 1, then the selected second-slot tank.
- On the strobe edge, latch the ordered candidate list (at most 3 entries) plus each candidate's ROM address.
- ROM address map:
  - Tank frame base by direction: up 0, right 1024, left 2048, down 3072.
  - Tank address = base + (DrawY-Y)*32 + (DrawX-X).
  - Bullet address = 4096 + (DrawY-Y)*8 + (DrawX-X).
  - Direction codes 000, 101, 110, 111 use the up frame.
- FSM, with cycle 0 being the cycle pixel_stb is sampled:
  - IDLE: on pixel_stb, latch candidates and go to ISSUE1.
  - ISSUE1 (cycle 1): drive rom_addr = candidate 0 address, or 0 if there are no candidates. Go to EVAL1.
  - EVAL1 (cycle 2): rom_data belongs to candidate 0.
    - If rom_data != KEY_COLOR, latch it as the result.
    - Otherwise, if candidate 1 exists, drive rom_addr = candidate 1 address and mark a second read pending.
    - Otherwise the result is BG_COLOR.
    - No candidates at all also gives BG_COLOR.
    - Go to EVAL2.
  - EVAL2 (cycle 3):
    - If a second read is pending, the result is rom_data when it is != KEY_COLOR, else BG_COLOR.
    - Candidate 2 is never fetched (read budget is 2 per pixel). A third layer showing through two transparent layers renders BG_COLOR.
    - Load VGA_R/G/B = result[23:16], [15:8], [7:0]. Go to IDLE.
  - IDLE (cycle 4): pix_valid=1 for exactly this cycle.
- Latency: fixed at 4 cycles from pixel_stb to pix_valid, independent of the fall-through path.
- Strobe spacing:
  - A pixel_stb at cycle 4 (back in IDLE) is accepted. Minimum spacing is 4 cycles.
  - A pixel_stb in ISSUE1/EVAL1/EVAL2 is dropped and sets overrun.
  - If overrun_clr and a dropping strobe occur in the same cycle, set wins.
- VGA_R/G/B hold their value between pix_valid pulses.
- Positions, dirs and mode are sampled only on the strobe edge. Changes mid-pixel do not affect that pixel.

Decomposition:
- Package sprite_pkg holds:
  - dir_t enum (UP=3'b001, RIGHT, LEFT, DOWN)
  - frame base constants
  - BULLET_BASE=13'd4096
  - layer_t enum (L_BULLET, L_TANK1, L_TANK2)
  - the ROM address width
- One sub-module: sprite_hit_addr. It is instantiated three times; combinational; takes pos, size, stride, base, dir, DrawX/DrawY and produces hit and addr.

Test Plan:
- Empty screen: strobe at (0,0), no sprites -> rom_addr=0, pix_valid 4 cycles later, RGB=FF/FF/FF.
- Tank 1 only: tankX1=100, tankY1=50, dir=010, strobe at (105,52) -> rom_addr=1024+64+5=1093 in cycle 1; rom_data=24'h123456 -> RGB=12/34/56.
- Bullet over tank: bullet_X=104, bullet_Y=50 overlapping tank 1, strobe at (105,52) -> first address 4096+16+1=4113.
  - If rom_data opaque 24'h00FF00 -> RGB=00/FF/00 with no second read.
  - If rom_data=FF0000 -> second address 1093 in cycle 2, and that data is output.
- Both layers transparent: both reads return FF0000 -> RGB=FF/FF/FF. Three stacked layers never produce a third read.
- Mode switch: mode=1, tank3 at (200,200), tank2 at (300,300); strobes at (210,210) and (310,310) -> first hits tank 3, second gives background.
- Overrun and reset: strobe at cycles 0 and 2 -> one pix_valid, overrun=1, cleared by overrun_clr. Reset_n low at cycle 2 -> no pix_valid, outputs at reset values immediately.
